// File: rtl/reg_pkg.sv
// -----------------------------------------------------------------------------
// reg_pkg
// Shared definitions for the switch register-table access path.
//   - arb_state_e : arbiter FSM encoding (IDLE / ACCESS / DONE)
//   - REG_ADDR_W / REG_DATA_W : default table address / data widths
//   - REG_* : register addresses decoded by the switch register table
//   - idx_width() : width of a binary index for an N-entry one-hot vector
// -----------------------------------------------------------------------------
package reg_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_e;

    localparam int REG_ADDR_W = 7;
    localparam int REG_DATA_W = 16;

    // Register map of the switch table
    localparam logic [REG_ADDR_W-1:0] REG_ID        = 7'h00;
    localparam logic [REG_ADDR_W-1:0] REG_CTRL      = 7'h01;
    localparam logic [REG_ADDR_W-1:0] REG_STATUS    = 7'h02;
    localparam logic [REG_ADDR_W-1:0] REG_PORT_EN   = 7'h04;
    localparam logic [REG_ADDR_W-1:0] REG_VLAN_BASE = 7'h10;
    localparam logic [REG_ADDR_W-1:0] REG_HASH_SEED = 7'h20;
    localparam logic [REG_ADDR_W-1:0] REG_MAC_BASE  = 7'h40;

    // A single-entry vector still needs a 1-bit index
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/arb_grant.sv
// -----------------------------------------------------------------------------
// arb_grant
// Combinational request picker. Searches req_i upwards starting at ptr_i,
// wrapping to 0, and returns the first requester found. With ptr_i tied to 0
// this is plain fixed priority (index 0 highest).
// Ports:
//   req_i   [N-1:0]     request vector
//   ptr_i   [IDX_W-1:0] index where the search starts
//   gnt_o   [N-1:0]     one-hot grant (all zero when nothing requests)
//   idx_o   [IDX_W-1:0] binary index of the granted requester
//   valid_o             at least one request present
// -----------------------------------------------------------------------------
module arb_grant
    import reg_pkg::*;
#(
    parameter int N     = 6,
    parameter int IDX_W = idx_width(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    logic found;

    // Two ascending passes: first the indices at or above the pointer, then
    // the ones below it. A pointer value >= N simply leaves the first pass
    // empty, which degrades gracefully to fixed priority.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        for (int c = 0; c < N; c++) begin
            if (!found && (c >= int'(ptr_i)) && req_i[c]) begin
                found    = 1'b1;
                gnt_o[c] = 1'b1;
                idx_o    = IDX_W'(c);
            end
        end
        for (int c = 0; c < N; c++) begin
            if (!found && (c < int'(ptr_i)) && req_i[c]) begin
                found    = 1'b1;
                gnt_o[c] = 1'b1;
                idx_o    = IDX_W'(c);
            end
        end
        valid_o = found;
    end

endmodule

// File: rtl/reg_arbiter.sv
// -----------------------------------------------------------------------------
// reg_arbiter
// Serialises single-beat register reads/writes from NUM_CH requesters onto one
// register-table access port. Each access takes IDLE -> ACCESS -> DONE, so a
// new grant is possible every third cycle.
//
// Build option: define REG_ARB_RR_EN for round-robin arbitration; without it
// channel 0 has the highest fixed priority.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   req_i [NUM_CH]   per-channel request, held until ack
//   we_i  [NUM_CH]   per-channel direction (1 = write)
//   addr_i           flattened addresses, channel i at [i*ADDR_W +: ADDR_W]
//   wdata_i          flattened write data, channel i at [i*DATA_W +: DATA_W]
//   ack_o [NUM_CH]   one-cycle one-hot completion pulse
//   err_o            with ack: write refused by WR_MASK
//   rdata_o          read data, held until the next read completes
//   busy_o           FSM not in IDLE
//   reg_wr_o/reg_rd_o  one-cycle table write / read strobes
//   reg_addr_o, reg_wdata_o  registered table address / write data
//   reg_rdata_i      table read data (combinational from reg_addr_o)
// -----------------------------------------------------------------------------
module reg_arbiter
    import reg_pkg::*;
#(
    parameter int                NUM_CH  = 6,
    parameter int                ADDR_W  = REG_ADDR_W,
    parameter int                DATA_W  = REG_DATA_W,
    parameter logic [NUM_CH-1:0] WR_MASK = {NUM_CH{1'b1}}
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_CH-1:0]          req_i,
    input  logic [NUM_CH-1:0]          we_i,
    input  logic [NUM_CH*ADDR_W-1:0]   addr_i,
    input  logic [NUM_CH*DATA_W-1:0]   wdata_i,
    output logic [NUM_CH-1:0]          ack_o,
    output logic                       err_o,
    output logic [DATA_W-1:0]          rdata_o,
    output logic                       busy_o,
    output logic                       reg_wr_o,
    output logic                       reg_rd_o,
    output logic [ADDR_W-1:0]          reg_addr_o,
    output logic [DATA_W-1:0]          reg_wdata_o,
    input  logic [DATA_W-1:0]          reg_rdata_i
);

    localparam int IDX_W = idx_width(NUM_CH);

    // Unpacked views of the flattened request buses
    logic [ADDR_W-1:0] addr_arr  [NUM_CH];
    logic [DATA_W-1:0] wdata_arr [NUM_CH];

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
            assign addr_arr[gi]  = addr_i[gi*ADDR_W +: ADDR_W];
            assign wdata_arr[gi] = wdata_i[gi*DATA_W +: DATA_W];
        end
    endgenerate

    logic [NUM_CH-1:0] gnt;
    logic [IDX_W-1:0]  gnt_idx;
    logic              gnt_vld;
    logic [IDX_W-1:0]  search_ptr;

    arb_grant #(
        .N     (NUM_CH),
        .IDX_W (IDX_W)
    ) u_grant (
        .req_i   (req_i),
        .ptr_i   (search_ptr),
        .gnt_o   (gnt),
        .idx_o   (gnt_idx),
        .valid_o (gnt_vld)
    );

    // Direction and permission of the channel being granted right now
    logic gnt_we;
    logic gnt_wr_ok;
    assign gnt_we    = |(gnt & we_i);
    assign gnt_wr_ok = |(gnt & we_i & WR_MASK);

`ifdef REG_ARB_RR_EN
    logic [IDX_W-1:0] rr_ptr_q;
    logic [IDX_W-1:0] rr_ptr_d;
    // Next search starts just past the winner, wrapping at NUM_CH-1
    assign rr_ptr_d   = (int'(gnt_idx) == NUM_CH - 1) ? '0 : gnt_idx + 1'b1;
    assign search_ptr = rr_ptr_q;
`else
    assign search_ptr = '0;
`endif

    arb_state_e        state_q;
    logic [IDX_W-1:0]  sel_q;
    logic              denied_q;
    logic [NUM_CH-1:0] ack_q;
    logic              err_q;
    logic [DATA_W-1:0] rdata_q;
    logic              reg_wr_q;
    logic              reg_rd_q;
    logic [ADDR_W-1:0] reg_addr_q;
    logic [DATA_W-1:0] reg_wdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            denied_q    <= 1'b0;
            ack_q       <= '0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            reg_wr_q    <= 1'b0;
            reg_rd_q    <= 1'b0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
`ifdef REG_ARB_RR_EN
            rr_ptr_q    <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (gnt_vld) begin
                        sel_q       <= gnt_idx;
                        reg_addr_q  <= addr_arr[gnt_idx];
                        reg_wdata_q <= wdata_arr[gnt_idx];
                        reg_wr_q    <= gnt_wr_ok;
                        reg_rd_q    <= ~gnt_we;
                        // A refused write issues no strobe at all
                        denied_q    <= gnt_we & ~gnt_wr_ok;
`ifdef REG_ARB_RR_EN
                        rr_ptr_q    <= rr_ptr_d;
`endif
                        state_q     <= ACCESS;
                    end
                end
                ACCESS: begin
                    reg_wr_q <= 1'b0;
                    reg_rd_q <= 1'b0;
                    // reg_rd_q is still high here exactly when this is a read,
                    // and the table has been presenting data for reg_addr_q
                    if (reg_rd_q) begin
                        rdata_q <= reg_rdata_i;
                    end
                    ack_q   <= {{(NUM_CH-1){1'b0}}, 1'b1} << sel_q;
                    err_q   <= denied_q;
                    state_q <= DONE;
                end
                DONE: begin
                    ack_q   <= '0;
                    err_q   <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ack_o       = ack_q;
    assign err_o       = err_q;
    assign rdata_o     = rdata_q;
    assign busy_o      = (state_q != IDLE);
    assign reg_wr_o    = reg_wr_q;
    assign reg_rd_o    = reg_rd_q;
    assign reg_addr_o  = reg_addr_q;
    assign reg_wdata_o = reg_wdata_q;

endmodule
